nonconsec_rep_monitor: RTL

- Synthesizable RTL monitor that checks the temporal rule "trigger |=> event[=REPS] ##1 done" in hardware.
- It sequences one evaluation attempt at a time through a small FSM and reports pass/fail pulses, a fail cause and saturating statistics.
- It sits beside a datapath as an on-chip protocol checker and is the hardware counterpart of our simulation-only assertions.
- Triggers that arrive while an attempt is active are counted and dropped; there is no overlapping-attempt support.

---
 rtl/nonconsec_rep_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/nonconsec_rep_monitor.sv
// On-chip checker for "trig |=> evt[=REPS] ##1 done", one attempt at a time.
// Ports: clk, rst_n, en_i/trig_i/evt_i/done_i in; busy/pass/fail/code/stats out.
module nonconsec_rep_monitor #(
  parameter int REPS    = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      trig_i,
  input  logic                      evt_i,
  input  logic                      done_i,
  output logic                      busy_o,
  output logic                      pass_o,
  output logic                      fail_o,
  output logic [1:0]                fail_code_o,
  output logic [$clog2(REPS+1)-1:0] reps_seen_o,
  output logic [CNT_W-1:0]          pass_cnt_o,
  output logic [CNT_W-1:0]          fail_cnt_o,
  output logic [CNT_W-1:0]          drop_cnt_o
);

  localparam int RW = $clog2(REPS+1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RW-1:0] LAST_REP = RW'(REPS-1);
  localparam logic [WW-1:0] TO_LAST =
    WW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] CODE_EXTRA = 2'd1;
  localparam logic [1:0] CODE_TMO   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    WAIT_DONE
  } state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   rep_cnt, rep_nx;
  logic [WW-1:0]   wait_cnt, wait_nx;
  logic            pass_nx, fail_nx;
  logic [1:0]      code_nx;
  logic            timeout;
  logic            drop;

  assign timeout = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign drop    = busy_o && en_i && trig_i;
  assign reps_seen_o = rep_cnt;

  always_comb begin
    state_nx = state;
    rep_nx   = rep_cnt;
    wait_nx  = wait_cnt;
    pass_nx  = 1'b0;
    fail_nx  = 1'b0;
    code_nx  = fail_code_o;
    unique case (state)
      IDLE: begin
        if (en_i && trig_i) begin
          state_nx = COUNT;
          rep_nx   = '0;
          wait_nx  = '0;
        end
      end
      COUNT: begin
        wait_nx = wait_cnt + WW'(1);
        if (evt_i) rep_nx = rep_cnt + RW'(1);
        // Timeout wins here: the REPS-th event alone resolves nothing.
        if (timeout) begin
          fail_nx  = 1'b1;
          code_nx  = CODE_TMO;
          state_nx = IDLE;
          rep_nx   = '0;
        end else if (evt_i && rep_cnt == LAST_REP) begin
          state_nx = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wait_nx = wait_cnt + WW'(1);
        if (done_i) begin
          pass_nx  = 1'b1;
          code_nx  = 2'd0;
          state_nx = IDLE;
          rep_nx   = '0;
        end else if (evt_i) begin
          fail_nx  = 1'b1;
          code_nx  = CODE_EXTRA;
          state_nx = IDLE;
          rep_nx   = '0;
        end else if (timeout) begin
          fail_nx  = 1'b1;
          code_nx  = CODE_TMO;
          state_nx = IDLE;
          rep_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        rep_nx   = '0;
      end
    endcase
    // Disable mid-attempt: silent abort, nothing recorded.
    if (state != IDLE && !en_i) begin
      state_nx = IDLE;
      rep_nx   = '0;
      wait_nx  = '0;
      pass_nx  = 1'b0;
      fail_nx  = 1'b0;
      code_nx  = fail_code_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rep_cnt     <= '0;
      wait_cnt    <= '0;
      busy_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_code_o <= 2'd0;
      pass_cnt_o  <= '0;
      fail_cnt_o  <= '0;
      drop_cnt_o  <= '0;
    end else begin
      state       <= state_nx;
      rep_cnt     <= rep_nx;
      wait_cnt    <= wait_nx;
      busy_o      <= (state_nx != IDLE);
      pass_o      <= pass_nx;
      fail_o      <= fail_nx;
      fail_code_o <= code_nx;
      if (pass_nx && pass_cnt_o != CNT_MAX)
        pass_cnt_o <= pass_cnt_o + CNT_W'(1);
      if (fail_nx && fail_cnt_o != CNT_MAX)
        fail_cnt_o <= fail_cnt_o + CNT_W'(1);
      if (drop && drop_cnt_o != CNT_MAX)
        drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end

endmodule
